// File: rtl/tdc_pingpong_buf.sv
// Ping-pong frame buffer for TDC time-of-flight samples.
// The front end fills one bank while the reader randomly addresses the other.
module tdc_pingpong_buf #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 11,
    parameter int DROP_CNT_W = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_en,
    input  logic [DATA_W-1:0]     i_wr_data,
    input  logic                  i_frame_end,
    output logic                  o_frame_rdy,
    output logic [ADDR_W:0]       o_frame_len,
    output logic                  o_frame_ovf,
    input  logic [ADDR_W-1:0]     i_rd_addr,
    output logic [DATA_W-1:0]     o_rd_data,
    input  logic                  i_rd_done,
    output logic                  o_drop_pls,
    output logic [DROP_CNT_W-1:0] o_drop_cnt
);

    logic [DATA_W-1:0] mem [0:2**(ADDR_W+1)-1];

    logic            wrBank;
    logic            rdBank;
    logic [ADDR_W:0] wrCnt;
    logic            ovfAcc;

    logic            wrAccept;
    logic            wrOvf;
    logic [ADDR_W:0] effCnt;
    logic            readerFree;

    // wrCnt tops out at DEPTH, so its MSB alone marks a full bank.
    assign wrAccept   = i_wr_en && !wrCnt[ADDR_W];
    assign wrOvf      = i_wr_en &&  wrCnt[ADDR_W];
    assign effCnt     = wrCnt + (ADDR_W+1)'(wrAccept);
    assign readerFree = !o_frame_rdy || i_rd_done;

    always_ff @(posedge i_clk) begin
        if (wrAccept) begin
            mem[{wrBank, wrCnt[ADDR_W-1:0]}] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_data <= '0;
        end else begin
            o_rd_data <= mem[{rdBank, i_rd_addr}];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wrBank      <= 1'b0;
            rdBank      <= 1'b0;
            wrCnt       <= '0;
            ovfAcc      <= 1'b0;
            o_frame_rdy <= 1'b0;
            o_frame_len <= '0;
            o_frame_ovf <= 1'b0;
            o_drop_pls  <= 1'b0;
            o_drop_cnt  <= '0;
        end else begin
            o_drop_pls <= 1'b0;
            if (wrAccept) begin
                wrCnt <= wrCnt + (ADDR_W+1)'(1);
            end
            if (wrOvf) begin
                ovfAcc <= 1'b1;
            end
            if (i_rd_done && o_frame_rdy) begin
                o_frame_rdy <= 1'b0;
                o_frame_len <= '0;
                o_frame_ovf <= 1'b0;
            end
            // Frame close overrides the per-sample updates above; a release in the
            // same cycle frees the reader so the new frame is handed straight over.
            if (i_frame_end && effCnt != '0) begin
                wrCnt  <= '0;
                ovfAcc <= 1'b0;
                if (readerFree) begin
                    rdBank      <= wrBank;
                    wrBank      <= ~wrBank;
                    o_frame_rdy <= 1'b1;
                    o_frame_len <= effCnt;
                    o_frame_ovf <= ovfAcc | wrOvf;
                end else begin
                    o_drop_pls <= 1'b1;
                    if (o_drop_cnt != '1) begin
                        o_drop_cnt <= o_drop_cnt + DROP_CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule
